// File: rtl/ps2_kbd_pkg.sv
// PS/2 keyboard shared types: receiver states and set-2 scan codes.
package ps2_kbd_pkg;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_ENTER  = 8'h5A;
   localparam logic [7:0] SC_BKSP   = 8'h66;
   localparam logic [7:0] SC_ESC    = 8'h76;

   function automatic logic is_letter(input logic [6:0] a);
      return (a >= 7'h61) && (a <= 7'h7A);
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receiver: synchronisers, clock glitch filter, frame FSM, timeout.
module ps2_rx
   import ps2_kbd_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 20000
)(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   output logic       o_valid,
   output logic [7:0] o_byte
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   logic [1:0]    r_clk_s;
   logic [1:0]    r_dat_s;
   logic          r_filt;
   logic [FW-1:0] r_fcnt;
   rx_state_t     r_state;
   logic [2:0]    r_bcnt;
   logic [7:0]    r_shift;
   logic          r_par;
   logic [TW-1:0] r_tcnt;
   logic          r_valid;
   logic          w_fall;
   logic          w_bit;

   assign w_bit  = r_dat_s[1];
   assign w_fall = r_filt & ~r_clk_s[1] & (r_fcnt == FLT_LAST);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_clk_s <= 2'b11;
         r_dat_s <= 2'b11;
         r_filt  <= 1'b1;
         r_fcnt  <= '0;
      end else begin
         r_clk_s <= {r_clk_s[0], i_ps2_clk};
         r_dat_s <= {r_dat_s[0], i_ps2_data};
         if (r_clk_s[1] == r_filt) begin
            r_fcnt <= '0;
         end else if (r_fcnt == FLT_LAST) begin
            r_filt <= r_clk_s[1];
            r_fcnt <= '0;
         end else begin
            r_fcnt <= r_fcnt + FW'(1);
         end
      end
   end

   // r_par accumulates data+parity; odd total means a good frame
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= RX_IDLE;
         r_bcnt  <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_tcnt  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (r_state == RX_IDLE || w_fall)
            r_tcnt <= '0;
         else
            r_tcnt <= r_tcnt + TW'(1);
         if (w_fall) begin
            unique case (r_state)
               RX_IDLE: begin
                  if (!w_bit) begin
                     r_state <= RX_DATA;
                     r_bcnt  <= '0;
                     r_par   <= 1'b0;
                  end
               end
               RX_DATA: begin
                  r_shift <= {w_bit, r_shift[7:1]};
                  r_par   <= r_par ^ w_bit;
                  r_bcnt  <= r_bcnt + 3'd1;
                  if (r_bcnt == 3'd7)
                     r_state <= RX_PARITY;
               end
               RX_PARITY: begin
                  r_par   <= r_par ^ w_bit;
                  r_state <= RX_STOP;
               end
               RX_STOP: begin
                  r_state <= RX_IDLE;
                  r_valid <= w_bit & r_par;
               end
               default: r_state <= RX_IDLE;
            endcase
         end else if (r_state != RX_IDLE && r_tcnt == TO_LAST) begin
            r_state <= RX_IDLE;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_byte  = r_shift;

endmodule

// File: rtl/ps2_kbd_ascii.sv
// PS/2 set-2 keyboard to ASCII: modifier tracking, key table, output latch.
module ps2_kbd_ascii
   import ps2_kbd_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 20000
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       keystrobe,
   output logic [7:0] keycode
);

   logic        w_valid;
   logic [7:0]  w_byte;
   logic [14:0] w_map;
   logic [6:0]  w_ascii;
   logic        w_shift;
   logic        w_key;
   logic        r_ext;
   logic        r_brk;
   logic        r_lsh;
   logic        r_rsh;
   logic        r_ctrl;
   logic        r_caps;
   logic [7:0]  r_keycode;

   ps2_rx #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_ps2_clk  (ps2_clk),
      .i_ps2_data (ps2_data),
      .o_valid    (w_valid),
      .o_byte     (w_byte)
   );

   // {hit, unshifted, shifted}
   function automatic logic [14:0] kmap(input logic [7:0] c);
      case (c)
         8'h1C: return {1'b1, 7'h61, 7'h41};
         8'h32: return {1'b1, 7'h62, 7'h42};
         8'h21: return {1'b1, 7'h63, 7'h43};
         8'h23: return {1'b1, 7'h64, 7'h44};
         8'h24: return {1'b1, 7'h65, 7'h45};
         8'h2B: return {1'b1, 7'h66, 7'h46};
         8'h34: return {1'b1, 7'h67, 7'h47};
         8'h33: return {1'b1, 7'h68, 7'h48};
         8'h43: return {1'b1, 7'h69, 7'h49};
         8'h3B: return {1'b1, 7'h6A, 7'h4A};
         8'h42: return {1'b1, 7'h6B, 7'h4B};
         8'h4B: return {1'b1, 7'h6C, 7'h4C};
         8'h3A: return {1'b1, 7'h6D, 7'h4D};
         8'h31: return {1'b1, 7'h6E, 7'h4E};
         8'h44: return {1'b1, 7'h6F, 7'h4F};
         8'h4D: return {1'b1, 7'h70, 7'h50};
         8'h15: return {1'b1, 7'h71, 7'h51};
         8'h2D: return {1'b1, 7'h72, 7'h52};
         8'h1B: return {1'b1, 7'h73, 7'h53};
         8'h2C: return {1'b1, 7'h74, 7'h54};
         8'h3C: return {1'b1, 7'h75, 7'h55};
         8'h2A: return {1'b1, 7'h76, 7'h56};
         8'h1D: return {1'b1, 7'h77, 7'h57};
         8'h22: return {1'b1, 7'h78, 7'h58};
         8'h35: return {1'b1, 7'h79, 7'h59};
         8'h1A: return {1'b1, 7'h7A, 7'h5A};
         8'h16: return {1'b1, 7'h31, 7'h21};
         8'h1E: return {1'b1, 7'h32, 7'h40};
         8'h26: return {1'b1, 7'h33, 7'h23};
         8'h25: return {1'b1, 7'h34, 7'h24};
         8'h2E: return {1'b1, 7'h35, 7'h25};
         8'h36: return {1'b1, 7'h36, 7'h5E};
         8'h3D: return {1'b1, 7'h37, 7'h26};
         8'h3E: return {1'b1, 7'h38, 7'h2A};
         8'h46: return {1'b1, 7'h39, 7'h28};
         8'h45: return {1'b1, 7'h30, 7'h29};
         8'h0E: return {1'b1, 7'h60, 7'h7E};
         8'h4E: return {1'b1, 7'h2D, 7'h5F};
         8'h55: return {1'b1, 7'h3D, 7'h2B};
         8'h54: return {1'b1, 7'h5B, 7'h7B};
         8'h5B: return {1'b1, 7'h5D, 7'h7D};
         8'h5D: return {1'b1, 7'h5C, 7'h7C};
         8'h4C: return {1'b1, 7'h3B, 7'h3A};
         8'h52: return {1'b1, 7'h27, 7'h22};
         8'h41: return {1'b1, 7'h2C, 7'h3C};
         8'h49: return {1'b1, 7'h2E, 7'h3E};
         8'h4A: return {1'b1, 7'h2F, 7'h3F};
         8'h29: return {1'b1, 7'h20, 7'h20};
         SC_ENTER: return {1'b1, 7'h0D, 7'h0D};
         SC_BKSP:  return {1'b1, 7'h08, 7'h08};
         SC_ESC:   return {1'b1, 7'h1B, 7'h1B};
         default:  return '0;
      endcase
   endfunction

   always_comb begin
      w_map   = kmap(w_byte);
      w_shift = r_lsh | r_rsh;
      w_ascii = w_shift ? w_map[6:0] : w_map[13:7];
      if (is_letter(w_map[13:7])) begin
         w_ascii = (w_shift ^ r_caps) ? w_map[6:0] : w_map[13:7];
         if (r_ctrl)
            w_ascii = w_ascii & 7'h1F;
      end
      w_key = w_valid & w_map[14] & ~r_ext & ~r_brk;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ext     <= 1'b0;
         r_brk     <= 1'b0;
         r_lsh     <= 1'b0;
         r_rsh     <= 1'b0;
         r_ctrl    <= 1'b0;
         r_caps    <= 1'b0;
         r_keycode <= 8'h00;
      end else begin
         if (w_valid) begin
            if (w_byte == SC_EXT) begin
               r_ext <= 1'b1;
            end else if (w_byte == SC_BRK) begin
               r_brk <= 1'b1;
            end else begin
               r_ext <= 1'b0;
               r_brk <= 1'b0;
               if (w_byte == SC_LSHIFT) r_lsh  <= ~r_brk;
               if (w_byte == SC_RSHIFT) r_rsh  <= ~r_brk;
               if (w_byte == SC_CTRL)   r_ctrl <= ~r_brk;
               if (w_byte == SC_CAPS && !r_brk)
                  r_caps <= ~r_caps;
            end
         end
         // a fresh key beats a simultaneous strobe
         if (w_key)
            r_keycode <= {1'b1, w_ascii};
         else if (keystrobe)
            r_keycode[7] <= 1'b0;
      end
   end

   assign keycode = r_keycode;

endmodule

// File: tb/tb_ps2_kbd_ascii.sv
// Randomized PS/2 frame bench for ps2_kbd_ascii against a keymap model.
module tb_ps2_kbd_ascii;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       keystrobe = 1'b0;
   logic [7:0] keycode;

   int n_checks = 0;
   int n_fail = 0;

   ps2_kbd_ascii #(
      .FILTER_LEN     (8),
      .TIMEOUT_CYCLES (400)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .keystrobe (keystrobe),
      .keycode   (keycode)
   );

   always #5 clk = ~clk;

   logic [7:0] let_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24,
      8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
      8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D,
      8'h22, 8'h35, 8'h1A};
   logic [7:0] dig_sc [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
      8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
   logic [7:0] pun_sc [11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B,
      8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
   logic [7:0] dig_lo [10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
      8'h36, 8'h37, 8'h38, 8'h39, 8'h30};
   logic [7:0] dig_hi [10] = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25,
      8'h5E, 8'h26, 8'h2A, 8'h28, 8'h29};
   logic [7:0] pun_lo [11] = '{8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D,
      8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
   logic [7:0] pun_hi [11] = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D,
      8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};

   logic m_ext, m_brk, m_ls, m_rs, m_ctrl, m_caps;
   logic [7:0] m_kc;

   task automatic check(input string tag, input logic [7:0] got,
                        input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [7:0] lookup(input logic [7:0] c);
      logic       sh;
      logic [7:0] ch;
      sh = m_ls | m_rs;
      for (int i = 0; i < 26; i++)
         if (c == let_sc[i]) begin
            ch = (sh ^ m_caps) ? 8'(8'h41 + i) : 8'(8'h61 + i);
            if (m_ctrl) ch = ch & 8'h1F;
            return {1'b1, ch[6:0]};
         end
      for (int i = 0; i < 10; i++)
         if (c == dig_sc[i]) begin
            ch = sh ? dig_hi[i] : dig_lo[i];
            return {1'b1, ch[6:0]};
         end
      for (int i = 0; i < 11; i++)
         if (c == pun_sc[i]) begin
            ch = sh ? pun_hi[i] : pun_lo[i];
            return {1'b1, ch[6:0]};
         end
      if (c == 8'h29) return 8'hA0;
      if (c == 8'h5A) return 8'h8D;
      if (c == 8'h66) return 8'h88;
      if (c == 8'h76) return 8'h9B;
      return 8'h00;
   endfunction

   task automatic model_reset();
      {m_ext, m_brk, m_ls, m_rs, m_ctrl, m_caps} = '0;
      m_kc = 8'h00;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [7:0] k;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
         if (!m_brk && !m_ext) begin
            k = lookup(b);
            if (k[7]) m_kc = k;
         end
         if (b == 8'h12) m_ls = !m_brk;
         if (b == 8'h59) m_rs = !m_brk;
         if (b == 8'h14) m_ctrl = !m_brk;
         if (b == 8'h58 && !m_brk) m_caps = !m_caps;
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad,
                             input bit glitch);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         ps2_data = f[i];
         wait_cyc(10);
         ps2_clk = 1'b0;
         wait_cyc(20);
         ps2_clk = 1'b1;
         if (glitch && i == 5) begin
            wait_cyc(3);
            ps2_clk = 1'b0;
            wait_cyc(3);
            ps2_clk = 1'b1;
            wait_cyc(4);
         end else begin
            wait_cyc(10);
         end
      end
      ps2_data = 1'b1;
      wait_cyc(30);
      if (!bad) model_byte(b);
   endtask

   task automatic send_partial(input int n);
      for (int i = 0; i <= n; i++) begin
         ps2_data = (i == 0) ? 1'b0 : 1'b1;
         wait_cyc(10);
         ps2_clk = 1'b0;
         wait_cyc(20);
         ps2_clk = 1'b1;
         wait_cyc(10);
      end
      ps2_data = 1'b1;
   endtask

   task automatic ks_pulse();
      @(negedge clk);
      keystrobe = 1'b1;
      @(negedge clk);
      keystrobe = 1'b0;
      m_kc[7] = 1'b0;
      wait_cyc(2);
   endtask

   function automatic logic [7:0] rand_key();
      int r;
      r = int'($urandom_range(0, 50));
      if (r < 26) return let_sc[r];
      if (r < 36) return dig_sc[r - 26];
      if (r < 47) return pun_sc[r - 36];
      if (r == 47) return 8'h29;
      if (r == 48) return 8'h5A;
      if (r == 49) return 8'h66;
      return 8'h76;
   endfunction

   function automatic logic [7:0] rand_mod();
      int r;
      r = int'($urandom_range(0, 3));
      if (r == 0) return 8'h12;
      if (r == 1) return 8'h59;
      if (r == 2) return 8'h14;
      return 8'h58;
   endfunction

   logic [7:0] got;
   logic [7:0] last_key;

   initial begin
      model_reset();
      wait_cyc(5);
      check("reset", keycode, 8'h00);
      reset = 1'b0;
      wait_cyc(5);

      send_frame(8'h1C, 0, 0);
      check("a_make", keycode, 8'hE1);
      ks_pulse();
      check("a_strobe", keycode, 8'h61);

      send_frame(8'h12, 0, 0);
      send_frame(8'h1C, 0, 0);
      check("shift_a", keycode, 8'hC1);
      send_frame(8'hF0, 0, 0);
      send_frame(8'h1C, 0, 0);
      check("brk_a", keycode, 8'hC1);
      send_frame(8'hF0, 0, 0);
      send_frame(8'h12, 0, 0);
      check("brk_shift", keycode, 8'hC1);
      send_frame(8'h1C, 0, 0);
      check("a_again", keycode, 8'hE1);

      send_frame(8'h5A, 1, 0);
      check("bad_par", keycode, 8'hE1);
      send_frame(8'h5A, 0, 0);
      check("enter", keycode, 8'h8D);

      send_partial(3);
      wait_cyc(500);
      send_frame(8'h16, 0, 0);
      check("timeout", keycode, 8'hB1);

      send_frame(8'h14, 0, 0);
      send_frame(8'h21, 0, 0);
      check("ctrl_c", keycode, 8'h83);
      send_frame(8'hF0, 0, 0);
      send_frame(8'h14, 0, 0);
      send_frame(8'h58, 0, 0);
      send_frame(8'hF0, 0, 0);
      send_frame(8'h58, 0, 0);
      send_frame(8'h1C, 0, 0);
      check("caps_a", keycode, 8'hC1);

      keystrobe = 1'b1;
      wait_cyc(2);
      got = 8'h00;
      fork
         send_frame(8'h29, 0, 0);
         begin
            for (int i = 0; i < 700; i++) begin
               @(negedge clk);
               if (keycode[7]) begin
                  got = keycode;
                  break;
               end
            end
         end
      join
      check("ks_load", got, 8'hA0);
      keystrobe = 1'b0;
      m_kc[7] = 1'b0;
      wait_cyc(2);
      check("ks_keep", keycode, 8'h20);

      send_partial(5);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      wait_cyc(3);
      check("mid_reset", keycode, 8'h00);
      reset = 1'b0;
      wait_cyc(5);
      send_frame(8'h1C, 0, 0);
      check("post_reset", keycode, 8'hE1);

      last_key = 8'h1C;
      for (int it = 0; it < 60; it++) begin
         int r;
         bit g;
         r = int'($urandom_range(0, 99));
         g = ($urandom_range(0, 3) == 0);
         if (r < 40) begin
            if (r < 8) send_frame(last_key, 0, g);
            else begin
               last_key = rand_key();
               send_frame(last_key, 0, g);
            end
         end else if (r < 52) begin
            send_frame(rand_mod(), 0, g);
         end else if (r < 67) begin
            send_frame(8'hF0, 0, g);
            send_frame(($urandom_range(0, 1) == 1) ? rand_mod()
                       : rand_key(), 0, 0);
         end else if (r < 74) begin
            send_frame(8'hE0, 0, 0);
            send_frame(($urandom_range(0, 1) == 1) ? 8'h14
                       : rand_key(), 0, g);
         end else if (r < 82) begin
            send_frame(rand_key(), 1, g);
         end else if (r < 88) begin
            send_frame(8'h05, 0, g);
         end else begin
            ks_pulse();
         end
         check("rnd", keycode, m_kc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
